// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus word, RAM handshake state and arbiter FSM state.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter, grouped for port passing.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Grant watchdog: counts grant cycles, saturates at TIMEOUT-1 and flags expiry.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_c_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] tcount_q;
  logic [CW-1:0] tcount_d;

  always_comb begin
    tcount_d = tcount_q;
    if (clr_i) begin
      tcount_d = '0;
    end else if (en_i && (tcount_q != LAST)) begin
      tcount_d = tcount_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcount_q <= '0;
    end else begin
      tcount_q <= tcount_d;
    end
  end

  assign timeout_c_o = en_i && (tcount_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache in front of a variable-latency RAM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned AW      = 32
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  arbstate_t     state_q, state_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] store_q, store_d;
  logic          last_d_q, last_d_d;
  logic          err_q, err_d;
  logic          tmr_clr;
  logic          tmr_en;
  logic          timeout_c;
  logic          live_c;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       (tmr_clr),
    .en_i        (tmr_en),
    .timeout_c_o (timeout_c)
  );

  // Arbitration, completion and abort decisions; wait/load are combinational.
  always_comb begin
    state_d   = state_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    store_d   = store_q;
    last_d_d  = last_d_q;
    err_d     = err_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    live_c    = 1'b0;
    bus.iwait = 1'b1;
    bus.dwait = 1'b1;
    bus.iload = '0;
    bus.dload = '0;

    unique case (state_q)
      IDLE: begin
        if ((bus.dREN || bus.dWEN) && !(bus.iREN && last_d_q)) begin
          state_d = DGNT;
          ren_d   = bus.dREN && !bus.dWEN;
          wen_d   = bus.dWEN;
          addr_d  = AW'(bus.daddr);
          store_d = AW'(bus.dstore);
          tmr_clr = 1'b1;
        end else if (bus.iREN) begin
          state_d = IGNT;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          addr_d  = AW'(bus.iaddr);
          tmr_clr = 1'b1;
        end
      end

      IGNT, DGNT: begin
        tmr_en = 1'b1;
        live_c = (state_q == IGNT) ? bus.iREN : (bus.dREN || bus.dWEN);
        // Any exit drops the enables so the RAM restarts its latency count.
        if (!live_c || (bus.ramstate == ACCESS) || (bus.ramstate == ERROR) || timeout_c) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
        if (live_c && (bus.ramstate == ACCESS)) begin
          last_d_d = (state_q == DGNT);
          if (state_q == IGNT) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end else begin
            bus.dwait = 1'b0;
            bus.dload = wen_q ? '0 : bus.ramload;
          end
        end else if (live_c && ((bus.ramstate == ERROR) || timeout_c)) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      last_d_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      last_d_q <= last_d_d;
      err_q    <= err_d;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = word_t'(addr_q);
  assign bus.ramstore = word_t'(store_q);
  assign bus.err      = err_q;

endmodule
